logical_or_arbiter: RTL and testbench



---
 rtl/logical_or_arbiter_pkg.sv | 13 +
 rtl/LogicalOR.sv | 35 +++
 rtl/logical_or_arbiter_rr_grant_select.sv | 35 +++
 rtl/logical_or_arbiter.sv | 171 +++++++++++++++++
 tb/tb_logical_or_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/logical_or_arbiter_pkg.sv
// Shared types and helpers for the logical-OR round-robin arbiter.
package logical_or_arbiter_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic int idx_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/LogicalOR.sv
// Logical OR of two N-bit operands: c = (a != 0) || (b != 0).
// MODEL selects the implementation style; an unknown name falls back to DataFlow.
module LogicalOR #(
    parameter int    N     = 8,
    parameter string MODEL = "Structural"
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         c
);

    if (MODEL == "Structural") begin : g_structural
        logic [2*N-1:0] ab_s;
        logic [2*N-1:0] chain_s;

        assign ab_s       = {a, b};
        assign chain_s[0] = ab_s[0];
        for (genvar g = 1; g < 2 * N; g++) begin : g_or_chain
            or u_or (chain_s[g], chain_s[g-1], ab_s[g]);
        end
        assign c = chain_s[2*N-1];
    end else if (MODEL == "Behavioral") begin : g_behavioral
        // Spelled out as the comparison itself rather than a reduction.
        always_comb begin
            if ((a != {N{1'b0}}) || (b != {N{1'b0}})) begin
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
        end
    end else begin : g_dataflow
        assign c = (|a) | (|b);
    end

endmodule

// File: rtl/logical_or_arbiter_rr_grant_select.sv
// Combinational round-robin picker: first set request at or after ptr_i, cyclically.
module rr_grant_select
    import logical_or_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand_s;

    // Walk the requests starting at the pointer and keep the first hit.
    always_comb begin
        gnt_o  = {NREQ{1'b0}};
        idx_o  = {IW{1'b0}};
        any_o  = 1'b0;
        cand_s = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IW'((int'(ptr_i) + k) % NREQ);
            if (!any_o && req_i[cand_s]) begin
                any_o         = 1'b1;
                idx_o         = cand_s;
                gnt_o[cand_s] = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/logical_or_arbiter.sv
// Round-robin arbiter sharing one LogicalOR between NREQ requesters, one-entry response slot.
// Optional per-requester saturating grant counters: LOGICAL_OR_ARBITER_STATS_EN.
module logical_or_arbiter
    import logical_or_arbiter_pkg::*;
#(
    parameter int    NREQ   = 4,
    parameter int    N      = 8,
    parameter string MODEL  = "Structural",
    parameter int    STAT_W = 16,
    localparam int   IW     = idx_w(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*N-1:0]  req_a,
    input  logic [NREQ*N-1:0]  req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_c,
    output logic [IW-1:0]      rsp_id
`ifdef LOGICAL_OR_ARBITER_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] grant_count
`endif
);

    if ((NREQ < 2) || (NREQ > 16) || (N < 1) || (STAT_W < 1)) begin : g_param_check
        $error("logical_or_arbiter: parameter out of range");
    end

    slot_state_t   state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          rsp_c_q, rsp_c_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;

    logic            can_issue_s;
    logic [NREQ-1:0] req_masked_s;
    logic [NREQ-1:0] gnt_s;
    logic [IW-1:0]   gnt_idx_s;
    logic            gnt_any_s;
    logic [N-1:0]    a_mux_s;
    logic [N-1:0]    b_mux_s;
    logic            or_c_s;

    // Nothing is granted while reset is held, so a reset edge never races a grant.
    assign can_issue_s  = !rst && ((state_q == SLOT_EMPTY) || rsp_ready);
    assign req_masked_s = req_valid & {NREQ{can_issue_s}};

    rr_grant_select #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_sel (
        .req_i (req_masked_s),
        .ptr_i (ptr_q),
        .gnt_o (gnt_s),
        .idx_o (gnt_idx_s),
        .any_o (gnt_any_s)
    );

    assign req_ready = gnt_s;

    // Route the granted requester's operands to the shared OR datapath.
    always_comb begin
        a_mux_s = {N{1'b0}};
        b_mux_s = {N{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_s[i]) begin
                a_mux_s = req_a[i*N +: N];
                b_mux_s = req_b[i*N +: N];
            end else begin
                a_mux_s = a_mux_s;
                b_mux_s = b_mux_s;
            end
        end
    end

    LogicalOR #(
        .N     (N),
        .MODEL (MODEL)
    ) u_or (
        .a (a_mux_s),
        .b (b_mux_s),
        .c (or_c_s)
    );

    // Slot next state; a grant while FULL refills the slot without a bubble.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rsp_c_d  = rsp_c_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (gnt_any_s) begin
                    state_d = SLOT_FULL;
                end else begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (gnt_any_s) begin
                    state_d = SLOT_FULL;
                end else if (rsp_ready) begin
                    state_d = SLOT_EMPTY;
                end else begin
                    state_d = SLOT_FULL;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase
        if (gnt_any_s) begin
            rsp_c_d  = or_c_s;
            rsp_id_d = gnt_idx_s;
            if (gnt_idx_s == IW'(NREQ - 1)) begin
                ptr_d = {IW{1'b0}};
            end else begin
                ptr_d = gnt_idx_s + IW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Slot, pointer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SLOT_EMPTY;
            ptr_q    <= {IW{1'b0}};
            rsp_c_q  <= 1'b0;
            rsp_id_q <= {IW{1'b0}};
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rsp_c_q  <= rsp_c_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == SLOT_FULL);
    assign rsp_c     = rsp_c_q;
    assign rsp_id    = rsp_id_q;

`ifdef LOGICAL_OR_ARBITER_STATS_EN
    logic [STAT_W-1:0] cnt_q [NREQ];

    // Per-requester grant counters that stop at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                cnt_q[i] <= {STAT_W{1'b0}};
            end else if (gnt_s[i] && (cnt_q[i] != {STAT_W{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + STAT_W'(1);
            end else begin
                cnt_q[i] <= cnt_q[i];
            end
        end
    end

    // Pack the counters onto the flat output bus.
    always_comb begin
        grant_count = {(NREQ*STAT_W){1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            grant_count[i*STAT_W +: STAT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_logical_or_arbiter.sv
// Directed bench with a response scoreboard for logical_or_arbiter (NREQ=4, N=8).
module tb_logical_or_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 8;
`ifdef LOGICAL_OR_ARBITER_STATS_EN
    localparam int STAT_W = 2;
`else
    localparam int STAT_W = 16;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_c;
    logic [1:0]        rsp_id;
`ifdef LOGICAL_OR_ARBITER_STATS_EN
    logic [NREQ*STAT_W-1:0] grant_count;
`endif

    logic [N-1:0] pend_a [NREQ];
    logic [N-1:0] pend_b [NREQ];
    logic [2:0]   sb [$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    logical_or_arbiter #(
        .NREQ   (NREQ),
        .N      (N),
        .MODEL  ("Structural"),
        .STAT_W (STAT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id)
`ifdef LOGICAL_OR_ARBITER_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        pend_a[i] = a;
        pend_b[i] = b;
    endtask

    // One cycle: drive after the edge, check the grant mid-cycle, record the expected response.
    task automatic cyc(input logic r, input logic [3:0] rv, input logic rr,
                       input logic [3:0] eg, input logic ec, input string nm);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = rv;
        rsp_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = pend_a[i];
            req_b[i*N +: N] = pend_b[i];
        end
        if (r) sb.delete();
        @(negedge clk);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'(eg));
        if (eg != 4'b0000) sb.push_back({oh2idx(eg), ec});
    endtask

    // Monitor: every accepted response must match the oldest expected one.
    always @(negedge clk) begin
        logic [2:0] e;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && rst === 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d c=%0d, expected no response", rsp_id, rsp_c);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_c} !== e) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d c=%0d, expected id=%0d c=%0d",
                             rsp_id, rsp_c, e[2:1], e[0]);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) set_op(i, 8'h01, 8'h00);

        // Reset with everyone requesting: no grants, empty slot.
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, "reset");
            chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        end

        // Round-robin order starting at requester 0, one grant per cycle.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, "rr");
        end

        // Operand patterns from requester 2 alone.
        set_op(2, 8'h00, 8'h00);
        cyc(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, "arith_zero");
        set_op(2, 8'h00, 8'h80);
        cyc(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, "arith_b80");
        set_op(2, 8'hFF, 8'hFF);
        cyc(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, "arith_ff");
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "drain1");

        // Backpressure: slot from requester 1 held while everyone requests.
        set_op(1, 8'h00, 8'h04);
        set_op(3, 8'h00, 8'h00);
        cyc(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, "fill");
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, "stall");
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_c", 32'(rsp_c), 32'd1);
            chk("stall_rsp_id", 32'(rsp_id), 32'd1);
        end
        cyc(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, "release");
        cyc(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0, "wrap");
        chk("wrap_rsp_valid", 32'(rsp_valid), 32'd1);

        // Reset while holding a response from requester 3.
        cyc(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, "midrst");
        cyc(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, "post_rst");
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "drain2");

`ifdef LOGICAL_OR_ARBITER_STATS_EN
        // Saturating counters: five grants to requester 0 with 2-bit counters.
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, "stat_rst");
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, "stat_gnt");
            if (k == 0) chk("stat_cleared", 32'(grant_count), 32'h00);
        end
        cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "stat_idle");
        chk("stat_saturated", 32'(grant_count), 32'h03);
        cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, "stat_rst2");
        cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, "stat_after");
        chk("stat_after_rst", 32'(grant_count), 32'h00);
`endif

        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            cyc(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "final_drain");
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
